axi_mem_responder: RTL and testbench

AXI4-Lite single-beat memory responder serving the data-cache controller's line refills and write-backs. It accepts read and write requests on independent channels and returns data and responses with a programmable read latency. It stands in for main memory in cache-subsystem simulation and for on-chip SRAM in the integrated design.

---
 rtl/axi_mem_responder_if.sv | 47 ++++
 rtl/axi_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// axi_mem_responder_if
// AXI4-Lite single-beat bus bundle between a requester (master) and the
// memory responder (slave). Clock and reset are not part of the bundle; they
// stay plain ports on each module.
//
// Signals:
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
// -----------------------------------------------------------------------------
interface axi_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
// AXI4-Lite single-beat memory responder. Independent write and read FSMs
// serve a word-addressed memory of MEM_DEPTH x DATA_W; reads are presented
// RD_LATENCY wait cycles after the AR handshake. Out-of-range accesses are
// answered with SLVERR (no write, read data 0).
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   axi_mem_responder_if.slave (AW, W, B, AR, R channels)
// -----------------------------------------------------------------------------
module axi_mem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_mem_responder_if.slave     bus
);

    localparam int   IDX_W = $clog2(MEM_DEPTH);
    localparam int   LANES = DATA_W / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // Depth expressed in word-index width so the range test compares the
    // full upper address, not a truncated index.
    localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2] < DEPTH_WORDS;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // ---------------------------------------------------------------- write
    w_state_t            w_state;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LANES-1:0]    wstrb_q;
    logic [1:0]          bresp_q;

    logic [ADDR_W-1:0]   commit_addr;
    logic [DATA_W-1:0]   commit_data;
    logic [LANES-1:0]    commit_strb;
    logic                commit_fire;
    logic                commit_we;

    // Commit happens on the edge that completes whichever handshake came
    // second; the missing half comes from the bus, the other from the latch.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        commit_addr = bus.awaddr;
        commit_data = bus.wdata;
        commit_strb = bus.wstrb;
        commit_fire = 1'b0;
        case (w_state)
            W_IDLE:   commit_fire = bus.awvalid && bus.wvalid;
            W_HAVE_A: begin
                commit_addr = waddr_q;
                commit_fire = bus.wvalid;
            end
            W_HAVE_D: begin
                commit_data = wdata_q;
                commit_strb = wstrb_q;
                commit_fire = bus.awvalid;
            end
            default:  commit_fire = 1'b0;
        endcase
    end

    // rst gates the memory write so nothing lands while reset is held.
    assign commit_we = commit_fire && rst && in_range(commit_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments here and in the memory block are
            // what give same-edge read-first behaviour and race-free state.
            case (w_state)
                W_IDLE: begin
                    if (commit_fire) begin
                        bresp_q <= in_range(commit_addr) ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end else if (bus.awvalid) begin
                        waddr_q <= bus.awaddr;
                        w_state <= W_HAVE_A;
                    end else if (bus.wvalid) begin
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        w_state <= W_HAVE_D;
                    end
                end
                W_HAVE_A, W_HAVE_D: begin
                    if (commit_fire) begin
                        bresp_q <= in_range(commit_addr) ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.bready) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the memory array has no reset; contents persist across rst and
    // a reset branch would prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (commit_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (commit_strb[b]) mem[word_idx(commit_addr)][8*b +: 8] <= commit_data[8*b +: 8];
            end
        end
    end

    assign bus.awready = (w_state == W_IDLE) || (w_state == W_HAVE_D);
    assign bus.wready  = (w_state == W_IDLE) || (w_state == W_HAVE_A);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = bresp_q;

    // ----------------------------------------------------------------- read
    r_state_t            r_state;
    logic [3:0]          rcnt;
    logic [ADDR_W-1:0]   raddr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;

    logic [ADDR_W-1:0]   sample_addr;
    logic [DATA_W-1:0]   sample_data;
    logic [1:0]          sample_resp;

    // With zero latency the sample is taken on the AR edge itself, straight
    // from the bus address; otherwise from the latched address.
    assign sample_addr = (r_state == R_IDLE) ? bus.araddr : raddr_q;
    assign sample_data = in_range(sample_addr) ? mem[word_idx(sample_addr)] : '0;
    assign sample_resp = in_range(sample_addr) ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            rcnt    <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        raddr_q <= bus.araddr;
                        rcnt    <= 4'(RD_LATENCY);
                        if (RD_LATENCY == 0) begin
                            rdata_q <= sample_data;
                            rresp_q <= sample_resp;
                            r_state <= R_DATA;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt == 4'd1) begin
                        rdata_q <= sample_data;
                        rresp_q <= sample_resp;
                        r_state <= R_DATA;
                    end else begin
                        rcnt <= rcnt - 4'd1;
                    end
                end
                R_DATA: begin
                    if (bus.rready) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_DATA);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_responder
// Directed and randomized bench for axi_mem_responder. A word-array model of
// the memory supplies every expected read value and response code; timing
// expectations come from the documented handshake latencies.
// -----------------------------------------------------------------------------
module tb_axi_mem_responder;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 256;
    localparam int RD_LAT    = 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [MEM_DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a >> 2) < MEM_DEPTH;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic bus_idle();
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    // AW and W in the same cycle; bready held low for bdelay cycles.
    task automatic write_op(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int bdelay);
        logic [1:0] er;
        er = addr_ok(a) ? OKAY : SLVERR;
        @(negedge clk);
        check("wr_awready_idle", bus.awready, 1);
        check("wr_wready_idle", bus.wready, 1);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (addr_ok(a)) model[a >> 2] = merge(model[a >> 2], d, s);
        check("wr_bvalid_t1", bus.bvalid, 1);
        check("wr_bresp", bus.bresp, er);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check("wr_bvalid_hold", bus.bvalid, 1);
            check("wr_bresp_hold", bus.bresp, er);
            check("wr_awready_busy", bus.awready, 0);
            check("wr_wready_busy", bus.wready, 0);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("wr_bvalid_drop", bus.bvalid, 0);
        check("wr_awready_back", bus.awready, 1);
    endtask

    // AR handshake, latency check, then rready held low for rdelay cycles.
    task automatic read_op(input logic [31:0] a, input int rdelay);
        logic [31:0] ed;
        logic [1:0]  er;
        ed = addr_ok(a) ? model[a >> 2] : 32'h0;
        er = addr_ok(a) ? OKAY : SLVERR;
        @(negedge clk);
        check("rd_arready_idle", bus.arready, 1);
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int k = 0; k < RD_LAT; k++) begin
            @(negedge clk);
            bus.arvalid = 1'b0;
            check("rd_rvalid_early", bus.rvalid, 0);
            check("rd_arready_busy", bus.arready, 0);
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("rd_rvalid_on_time", bus.rvalid, 1);
        check("rd_rdata", bus.rdata, ed);
        check("rd_rresp", bus.rresp, er);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            check("rd_rvalid_hold", bus.rvalid, 1);
            check("rd_rdata_hold", bus.rdata, ed);
            check("rd_rresp_hold", bus.rresp, er);
            check("rd_arready_hold", bus.arready, 0);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("rd_rvalid_drop", bus.rvalid, 0);
        check("rd_arready_back", bus.arready, 1);
    endtask

    task automatic check_reset_outputs(input string when);
        check({when, "_awready"}, bus.awready, 1);
        check({when, "_wready"}, bus.wready, 1);
        check({when, "_arready"}, bus.arready, 1);
        check({when, "_bvalid"}, bus.bvalid, 0);
        check({when, "_rvalid"}, bus.rvalid, 0);
        check({when, "_bresp"}, bus.bresp, OKAY);
        check({when, "_rresp"}, bus.rresp, OKAY);
        check({when, "_rdata"}, bus.rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        bus_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_released");

        // Basic same-cycle write then read-back.
        write_op(32'h10, 32'hDEADBEEF, 4'hF, 0);
        read_op(32'h10, 0);

        // AW first, W three cycles later.
        @(negedge clk);
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.awvalid = 1'b0;
            check("aw_first_awready", bus.awready, 0);
            check("aw_first_wready", bus.wready, 1);
            check("aw_first_bvalid", bus.bvalid, 0);
        end
        bus.wdata = 32'h11223344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        model[32'h20 >> 2] = 32'h11223344;
        check("aw_first_bvalid_c4", bus.bvalid, 1);
        check("aw_first_bresp", bus.bresp, OKAY);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;

        // W first, AW one cycle later.
        @(negedge clk);
        check("w_first_wready_idle", bus.wready, 1);
        bus.wdata = 32'hAABBCCDD; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("w_first_wready", bus.wready, 0);
        check("w_first_awready", bus.awready, 1);
        check("w_first_bvalid_early", bus.bvalid, 0);
        bus.awaddr = 32'h24; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        model[32'h24 >> 2] = 32'hAABBCCDD;
        check("w_first_bvalid", bus.bvalid, 1);
        check("w_first_bresp", bus.bresp, OKAY);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        read_op(32'h20, 0);
        read_op(32'h24, 0);

        // Partial write: expected word 0xFF34FF78.
        write_op(32'h0, 32'hFFFFFFFF, 4'hF, 0);
        write_op(32'h0, 32'h12345678, 4'b0101, 0);
        read_op(32'h0, 0);

        // Backpressure on both response channels.
        write_op(32'h30, $urandom, 4'hF, 5);
        read_op(32'h30, 5);

        // Out of range: index 256 aliases word 0 if the range test is missing.
        write_op(32'h400, 32'hCAFEF00D, 4'hF, 0);
        read_op(32'h400, 0);
        read_op(32'h0, 0);

        // Same-edge collision: read sample and write commit to word 2.
        write_op(32'h8, 32'h1, 4'hF, 0);
        @(negedge clk);
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        for (int k = 1; k <= RD_LAT; k++) begin
            @(negedge clk);
            bus.arvalid = 1'b0;
            if (k == RD_LAT) begin
                bus.awaddr = 32'h8; bus.awvalid = 1'b1;
                bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
            end
        end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("collide_rvalid", bus.rvalid, 1);
        check("collide_rdata_old", bus.rdata, 32'h1);
        check("collide_bvalid", bus.bvalid, 1);
        model[2] = 32'h2;
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0; bus.bready = 1'b0;
        read_op(32'h8, 0);

        // Reset while the read FSM is waiting.
        @(negedge clk);
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("rst_rwait_arready_busy", bus.arready, 0);
        #1 rst = 1'b0;
        #1 check_reset_outputs("rst_mid_read");
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < RD_LAT + 2; c++) begin
            @(negedge clk);
            check("rst_no_stale_rvalid", bus.rvalid, 0);
            check("rst_arready_idle", bus.arready, 1);
        end
        read_op(32'h10, 0);

        // Reset after AW only: the latched address must be discarded.
        @(negedge clk);
        bus.awaddr = 32'h44; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("rst_aw_discarded_bvalid", bus.bvalid, 0);
        check("rst_aw_discarded_awready", bus.awready, 1);
        bus.awaddr = 32'h48; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        model[32'h48 >> 2] = 32'h5A5A5A5A;
        check("rst_aw_late_bvalid", bus.bvalid, 1);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        read_op(32'h48, 0);

        // Randomized phase: fill every word, then mix reads and writes.
        for (int i = 0; i < MEM_DEPTH; i++) write_op(32'(i) << 2, $urandom, 4'hF, 0);
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, MEM_DEPTH + 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                write_op(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            else
                read_op(a, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
